// File: rtl/axi4l2core.sv
// AXI4-Lite slave to req/gnt core bridge; one core transaction in flight at a time.
// Optional address window check: define AXI4L2CORE_RANGE_CHK_EN to answer out-of-window accesses with DECERR.
`timescale 1ns/1ps
module axi4l2core #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] SIZE       = ADDR_WIDTH'(32'h0001_0000)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    core_req,
  input  logic                    core_gnt,
  output logic [ADDR_WIDTH-1:0]   core_addr,
  output logic                    core_we,
  output logic [DATA_WIDTH/8-1:0] core_be,
  output logic [DATA_WIDTH-1:0]   core_wdata,
  input  logic                    core_rvalid,
  input  logic [DATA_WIDTH-1:0]   core_rdata,
  input  logic                    core_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_RD_RESP, ST_WR_REQ, ST_WR_WAIT, ST_WR_RESP
  } state_t;

  state_t                 state;
  logic                   ready_en;
  logic                   last_rd;
  logic                   aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0]  aw_addr_reg, ar_addr_reg;
  logic [DATA_WIDTH-1:0]  w_data_reg;
  logic [STRB_W-1:0]      w_strb_reg;

  logic                   aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0]  aw_eff_addr, ar_eff_addr;
  logic [DATA_WIDTH-1:0]  w_eff_data;
  logic [STRB_W-1:0]      w_eff_strb;
  logic                   rd_elig, wr_elig, pick_rd, pick_wr;
  logic                   rd_hit, wr_hit;
  logic                   ar_clr, wr_clr;
  logic                   unused_ok;

  // ready_en keeps all readies low until the first clock edge after reset is released
  assign awready = ready_en & ~aw_full;
  assign wready  = ready_en & ~w_full;
  assign arready = ready_en & ~ar_full;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;

  // Requests arriving this cycle are visible to the arbiter directly, saving a cycle of latency
  assign aw_eff_addr = aw_full ? aw_addr_reg : awaddr;
  assign ar_eff_addr = ar_full ? ar_addr_reg : araddr;
  assign w_eff_data  = w_full ? w_data_reg : wdata;
  assign w_eff_strb  = w_full ? w_strb_reg : wstrb;

  assign rd_elig = ar_full | ar_hs;
  assign wr_elig = (aw_full | aw_hs) & (w_full | w_hs);
  assign pick_rd = (state == ST_IDLE) & rd_elig & (~wr_elig | ~last_rd);
  assign pick_wr = (state == ST_IDLE) & wr_elig & ~pick_rd;

`ifdef AXI4L2CORE_RANGE_CHK_EN
  assign rd_hit = (ar_eff_addr - BASE_ADDR) < SIZE;
  assign wr_hit = (aw_eff_addr - BASE_ADDR) < SIZE;
`else
  assign rd_hit = 1'b1;
  assign wr_hit = 1'b1;
`endif

  assign ar_clr = (pick_rd & ~rd_hit) | ((state == ST_RD_REQ) & core_gnt);
  assign wr_clr = (pick_wr & ~wr_hit) | ((state == ST_WR_REQ) & core_gnt);

  assign unused_ok = ^{awprot, arprot, aw_eff_addr[1:0], ar_eff_addr[1:0], BASE_ADDR, SIZE};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ready_en    <= 1'b0;
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      ar_full     <= 1'b0;
      aw_addr_reg <= '0;
      ar_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
    end else begin
      ready_en <= 1'b1;
      // A consuming clear wins over a same-edge load of a bypassed request
      if (ar_clr) begin
        ar_full <= 1'b0;
      end else if (ar_hs) begin
        ar_full     <= 1'b1;
        ar_addr_reg <= araddr;
      end
      if (wr_clr) begin
        aw_full <= 1'b0;
      end else if (aw_hs) begin
        aw_full     <= 1'b1;
        aw_addr_reg <= awaddr;
      end
      if (wr_clr) begin
        w_full <= 1'b0;
      end else if (w_hs) begin
        w_full     <= 1'b1;
        w_data_reg <= wdata;
        w_strb_reg <= wstrb;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= ST_IDLE;
      last_rd    <= 1'b0;
      core_req   <= 1'b0;
      core_addr  <= '0;
      core_we    <= 1'b0;
      core_be    <= '0;
      core_wdata <= '0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      rresp      <= RESP_OKAY;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_rd) begin
            last_rd   <= 1'b1;
            core_addr <= {ar_eff_addr[ADDR_WIDTH-1:2], 2'b00};
            core_we   <= 1'b0;
            if (rd_hit) begin
              core_req <= 1'b1;
              state    <= ST_RD_REQ;
            end else begin
              rvalid <= 1'b1;
              rdata  <= '0;
              rresp  <= RESP_DECERR;
              state  <= ST_RD_RESP;
            end
          end else if (pick_wr) begin
            last_rd    <= 1'b0;
            core_addr  <= {aw_eff_addr[ADDR_WIDTH-1:2], 2'b00};
            core_we    <= 1'b1;
            core_be    <= w_eff_strb;
            core_wdata <= w_eff_data;
            if (wr_hit) begin
              core_req <= 1'b1;
              state    <= ST_WR_REQ;
            end else begin
              bvalid <= 1'b1;
              bresp  <= RESP_DECERR;
              state  <= ST_WR_RESP;
            end
          end
        end
        ST_RD_REQ: begin
          if (core_gnt) begin
            core_req <= 1'b0;
            state    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (core_rvalid) begin
            rvalid <= 1'b1;
            rdata  <= core_rdata;
            rresp  <= core_err ? RESP_SLVERR : RESP_OKAY;
            state  <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_WR_REQ: begin
          if (core_gnt) begin
            core_req <= 1'b0;
            state    <= ST_WR_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (core_rvalid) begin
            bvalid <= 1'b1;
            bresp  <= core_err ? RESP_SLVERR : RESP_OKAY;
            state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          core_req <= 1'b0;
          rvalid   <= 1'b0;
          bvalid   <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4l2core.sv
// Bench for axi4l2core: reset, vector table, hand-built corner sequences and randomized traffic vs. a transaction-level model.
`timescale 1ns/1ps
module tb_axi4l2core;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [2:0]  awprot = 0, arprot = 0;
  logic [3:0]  wstrb = 0;
  logic [1:0]  bresp, rresp;
  logic        arvalid = 0, arready, rvalid, rready = 0;
  logic        core_req, core_gnt, core_we, core_rvalid, core_err;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_be;

  always #5 aclk = ~aclk;

  axi4l2core #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .core_req(core_req), .core_gnt(core_gnt), .core_addr(core_addr), .core_we(core_we),
    .core_be(core_be), .core_wdata(core_wdata), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .core_err(core_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core-side transactions as seen by the bench, in issue order
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cap_t;
  cap_t cap_q[$];

  int          cfg_gnt_delay = 0;
  int          cfg_rv_delay  = 0;
  logic [31:0] cfg_rdata     = 0;
  logic        cfg_err       = 0;
  bit          slave_en      = 1;
  bit          m_last_rd     = 0;  // model: kind served last was a read

  // Core responder: grants after cfg_gnt_delay, answers cfg_rv_delay cycles after the grant
  initial begin : core_slave
    logic [31:0] a0;
    core_gnt = 0; core_rvalid = 0; core_rdata = 0; core_err = 0;
    forever begin
      @(negedge aclk);
      if (slave_en && core_req && !areset) begin
        cap_q.push_back('{addr: core_addr, we: core_we, be: core_be, wdata: core_wdata});
        a0 = core_addr;
        for (int i = 0; i < cfg_gnt_delay; i++) begin
          @(negedge aclk);
          chk("req_stable", {31'd0, core_req, a0}, {31'd0, 1'b1, a0});
          chk("req_addr_stable", core_addr, a0);
        end
        core_gnt = 1;
        @(negedge aclk);
        core_gnt = 0;
        chk("req_drop_after_gnt", core_req, 0);
        for (int i = 0; i < cfg_rv_delay; i++) @(negedge aclk);
        core_rvalid = 1; core_rdata = cfg_rdata; core_err = cfg_err;
        @(negedge aclk);
        core_rvalid = 0; core_err = 0;
        chk("resp_latency", rvalid | bvalid, 1);
      end
    end
  end

  always @(negedge aclk) begin
    if (!areset) chk("rv_bv_exclusive", rvalid & bvalid, 0);
  end

  task automatic send_aw(input logic [31:0] a);
    bit ok = 0;
    awaddr = a; awprot = 3'b010; awvalid = 1;
    for (int i = 0; i < 100; i++) begin
      if (awready) begin @(posedge aclk); #1; ok = 1; break; end
      @(negedge aclk);
    end
    awvalid = 0;
    chk("aw_accept", ok, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    wdata = d; wstrb = s; wvalid = 1;
    for (int i = 0; i < 100; i++) begin
      if (wready) begin @(posedge aclk); #1; ok = 1; break; end
      @(negedge aclk);
    end
    wvalid = 0;
    chk("w_accept", ok, 1);
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit ok = 0;
    araddr = a; arprot = 3'b001; arvalid = 1;
    for (int i = 0; i < 100; i++) begin
      if (arready) begin @(posedge aclk); #1; ok = 1; break; end
      @(negedge aclk);
    end
    arvalid = 0;
    chk("ar_accept", ok, 1);
  endtask

  task automatic wait_resp(input bit is_wr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int hold, input string tag);
    bit got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (is_wr ? bvalid : rvalid) begin got = 1; break; end
    end
    chk({tag, "_valid"}, got, 1);
    if (!got) return;
    if (is_wr) chk({tag, "_bresp"}, bresp, exp_resp);
    else begin
      chk({tag, "_rresp"}, rresp, exp_resp);
      chk({tag, "_rdata"}, rdata, exp_data);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      if (is_wr) chk({tag, "_bhold"}, {bvalid, bresp}, {1'b1, exp_resp});
      else chk({tag, "_rhold"}, {rvalid, rresp, rdata}, {1'b1, exp_resp, exp_data});
    end
    if (is_wr) bready = 1; else rready = 1;
    @(posedge aclk); #1;
    bready = 0; rready = 0;
    chk({tag, "_valid_drop"}, is_wr ? bvalid : rvalid, 0);
  endtask

  task automatic chk_cap(input int idx, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input string tag);
    if (cap_q.size() <= idx) begin
      chk({tag, "_cap_count"}, cap_q.size(), idx + 1);
      return;
    end
    chk({tag, "_core_addr"}, cap_q[idx].addr, a & 32'hFFFF_FFFC);
    chk({tag, "_core_we"}, cap_q[idx].we, wr);
    if (wr) begin
      chk({tag, "_core_be"}, cap_q[idx].be, s);
      chk({tag, "_core_wdata"}, cap_q[idx].wdata, d);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [31:0] crdata;
    bit          err;
    int          gd;
    int          rvd;
    int          hold;
    logic [1:0]  exp_resp;
    logic [31:0] exp_caddr;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vt[6];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] ra, wa, wd;
    logic [3:0]  ws;
    int          mode, hold, nk;
    bit          kinds[2];

    vt[0] = '{0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0, 0, 1, 0, OKAY,   32'h10,   32'hDEAD_BEEF};
    vt[1] = '{0, 32'h0000_0023, 32'h0,         4'h0, 32'h0BAD_F00D, 0, 2, 0, 1, OKAY,   32'h20,   32'h0BAD_F00D};
    vt[2] = '{1, 32'h0000_0044, 32'hCAFE_F00D, 4'h0, 32'h0,         0, 1, 3, 0, OKAY,   32'h44,   32'h0};
    vt[3] = '{1, 32'h0000_0100, 32'h1122_3344, 4'hF, 32'h0,         1, 0, 0, 5, SLVERR, 32'h100,  32'h0};
    vt[4] = '{0, 32'h0000_0200, 32'h0,         4'h0, 32'h55AA_55AA, 1, 1, 2, 5, SLVERR, 32'h200,  32'h55AA_55AA};
    vt[5] = '{1, 32'h0000_FFFE, 32'hA5A5_5A5A, 4'h8, 32'h0,         0, 3, 1, 2, OKAY,   32'hFFFC, 32'h0};

    // Reset values are forced asynchronously
    #1 areset = 1;
    #2;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_outputs", {core_req, bvalid, rvalid, bresp, rresp}, 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(negedge aclk);
    areset = 0;
    #1 chk("rst_ready_wait_edge", {awready, wready, arready}, 3'b000);
    @(posedge aclk); #1;
    chk("rst_ready_rise", {awready, wready, arready}, 3'b111);

    // Read and write eligible together: read first, grant stalled 4 cycles
    cfg_gnt_delay = 4; cfg_rv_delay = 0; cfg_rdata = 32'h0F0F_1234; cfg_err = 0;
    cap_q.delete();
    fork
      send_ar(32'h300);
      send_aw(32'h400);
      send_w(32'h7777_8888, 4'b0110);
    join
    @(negedge aclk);
    chk("both_first_req", {core_req, core_we}, 2'b10);
    wait_resp(0, 32'h0F0F_1234, OKAY, 0, "both_rd");
    wait_resp(1, 32'h0, OKAY, 0, "both_wr");
    chk_cap(0, 0, 32'h300, 0, 0, "both_first");
    chk_cap(1, 1, 32'h400, 32'h7777_8888, 4'b0110, "both_second");
    m_last_rd = 0;

    for (int v = 0; v < 6; v++) begin
      cfg_gnt_delay = vt[v].gd; cfg_rv_delay = vt[v].rvd;
      cfg_rdata = vt[v].crdata; cfg_err = vt[v].err;
      cap_q.delete();
      if (vt[v].wr) fork send_aw(vt[v].addr); send_w(vt[v].wd, vt[v].strb); join
      else send_ar(vt[v].addr);
      wait_resp(vt[v].wr, vt[v].exp_rdata, vt[v].exp_resp, vt[v].hold, $sformatf("vec%0d", v));
      chk_cap(0, vt[v].wr, vt[v].exp_caddr, vt[v].wd, vt[v].strb, $sformatf("vec%0d", v));
      m_last_rd = !vt[v].wr;
    end

    // W three cycles ahead of AW: nothing issued until both are held
    cfg_gnt_delay = 0; cfg_rv_delay = 1; cfg_err = 0;
    cap_q.delete();
    send_w(32'h1234_5678, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("w_only_no_req", {core_req, wready}, 2'b00);
    end
    send_aw(32'h20);
    wait_resp(1, 32'h0, OKAY, 0, "w_first");
    chk_cap(0, 1, 32'h20, 32'h1234_5678, 4'b0011, "w_first");
    m_last_rd = 0;

    // Address just past the default window
    cap_q.delete();
    cfg_rdata = 32'h3141_5926; cfg_gnt_delay = 0; cfg_rv_delay = 0;
    send_ar(32'h0001_0000);
`ifdef AXI4L2CORE_RANGE_CHK_EN
    wait_resp(0, 32'h0, DECERR, 1, "oor_rd");
    chk("oor_no_core", cap_q.size(), 0);
`else
    wait_resp(0, 32'h3141_5926, OKAY, 1, "oor_rd");
    chk_cap(0, 0, 32'h0001_0000, 0, 0, "oor_rd");
`endif
    m_last_rd = 1;

    // Reset while waiting for the core's read data
    slave_en = 0;
    send_ar(32'h40);
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge aclk);
        if (core_req) begin seen = 1; break; end
      end
      chk("rst_mid_req_seen", seen, 1);
    end
    core_gnt = 1;
    @(negedge aclk);
    core_gnt = 0;
    #2 areset = 1;
    #1;
    chk("rst_mid_async", {core_req, rvalid, bvalid, arready}, 4'b0000);
    @(negedge aclk);
    areset = 0;
    @(negedge aclk);
    core_rvalid = 1; core_rdata = 32'hBAD0_BAD0;
    @(negedge aclk);
    core_rvalid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("rst_stray_rvalid", {rvalid, bvalid, core_req}, 3'b000);
    end
    slave_en = 1;
    m_last_rd = 0;

    // Randomized traffic against a transaction-level model
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);
      ra = $urandom_range(0, 32'hFFFF); wa = $urandom_range(0, 32'hFFFF);
      wd = $urandom; ws = 4'($urandom_range(0, 15));
      cfg_rdata = $urandom; cfg_err = 1'($urandom_range(0, 1));
      cfg_gnt_delay = $urandom_range(0, 3); cfg_rv_delay = $urandom_range(0, 3);
      hold = $urandom_range(0, 2);
      cap_q.delete();
      if (mode == 0) begin nk = 1; kinds[0] = 0; end
      else if (mode == 1) begin nk = 1; kinds[0] = 1; end
      else begin nk = 2; kinds[0] = m_last_rd; kinds[1] = !m_last_rd; end
      case (mode)
        0: send_ar(ra);
        1: fork send_aw(wa); send_w(wd, ws); join
        default: fork send_ar(ra); send_aw(wa); send_w(wd, ws); join
      endcase
      for (int k = 0; k < nk; k++) begin
        wait_resp(kinds[k], cfg_rdata, cfg_err ? SLVERR : OKAY, hold, $sformatf("rnd%0d_%0d", it, k));
        if (kinds[k]) chk_cap(k, 1, wa, wd, ws, $sformatf("rnd%0d_%0d", it, k));
        else chk_cap(k, 0, ra, 0, 0, $sformatf("rnd%0d_%0d", it, k));
        m_last_rd = !kinds[k];
      end
    end

    repeat (3) @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
